// File: rtl/dmw_row_reorder_if.sv
// AXI-stream style handshake bundle (tdata/tvalid/tready) used for the
// config, input and output channels of the row reorder buffer.
interface dmw_row_reorder_if #(
  parameter int DW = 128
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dmw_row_reorder.sv
// Row reorder buffer: turns a channel-group-major conv row into a
// pixel-major row for the S2MM datamover using two ping-pong banks.
//
// state | meaning
// IDLE  | waiting for a config word, config channel ready
// RUN   | rows being written into / read out of the ping-pong banks
module dmw_row_reorder #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  dmw_row_reorder_if.slave         s_axis_rrcfg,
  dmw_row_reorder_if.slave         s_axis_rr,
  dmw_row_reorder_if.master        m_axis_rr,
  output logic                     busy,
  output logic [11:0]              rows_done,
  output logic                     cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  logic [11:0]   w_q, r_q, wr_x, rows_wr;
  logic [3:0]    g_q, wr_g;
  logic [15:0]   p_q;
  logic [AW-1:0] wr_addr, iss_addr;
  logic [1:0]    full, issued;
  logic          wr_bank, rd_bank, iss_bank;

  logic [127:0]  mem0 [DEPTH];
  logic [127:0]  mem1 [DEPTH];
  logic [127:0]  rd_data_q;
  logic          rd_vld_q, rd_last_q;

  // two-entry prefetch; entry 0 is the beat presented downstream
  logic [127:0]  f_data [2];
  logic [1:0]    f_last;
  logic [1:0]    f_cnt;

  logic [11:0]   cfg_w, cfg_r;
  logic [3:0]    cfg_g;
  logic [15:0]   cfg_p;
  logic          cfg_hs, wr_hs, wr_col_end, wr_row_end;
  logic          out_hs, rd_row_end, iss_go, iss_end;
  logic [1:0]    cnt_after_pop;
  logic          cfg_unused;

  assign cfg_w      = s_axis_rrcfg.tdata[11:0];
  assign cfg_g      = s_axis_rrcfg.tdata[15:12];
  assign cfg_r      = s_axis_rrcfg.tdata[27:16];
  assign cfg_unused = ^s_axis_rrcfg.tdata[31:28];
  assign cfg_p      = 16'(cfg_w) * 16'(cfg_g);

  assign s_axis_rrcfg.tready = (state == IDLE);
  assign cfg_hs = s_axis_rrcfg.tvalid & s_axis_rrcfg.tready;

  assign s_axis_rr.tready = (state == RUN) & ~full[wr_bank] & (rows_wr < r_q);
  assign wr_hs      = s_axis_rr.tvalid & s_axis_rr.tready;
  assign wr_col_end = (wr_x == w_q - 12'd1);
  assign wr_row_end = wr_col_end & (wr_g == g_q - 4'd1);

  assign m_axis_rr.tvalid = (f_cnt != 2'd0);
  assign m_axis_rr.tdata  = f_data[0];
  assign out_hs     = m_axis_rr.tvalid & m_axis_rr.tready;
  assign rd_row_end = out_hs & f_last[0];

  // Issue a read only if the beat is guaranteed a prefetch slot; counting
  // the pop in the same cycle keeps the stream at one beat per cycle.
  // Issue runs ahead into the other bank so rows leave back to back.
  assign cnt_after_pop = f_cnt - {1'b0, out_hs};
  assign iss_go  = (state == RUN) & full[iss_bank] & ~issued[iss_bank] &
                   (({1'b0, cnt_after_pop} + {2'b0, rd_vld_q}) < 3'd2);
  assign iss_end = (16'(iss_addr) == p_q - 16'd1);

  // config decode, run control, bank ownership flags and row counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      rows_done <= '0;
      rows_wr   <= '0;
      w_q       <= '0;
      g_q       <= '0;
      r_q       <= '0;
      p_q       <= '0;
      full      <= '0;
      issued    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      iss_bank  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_hs) begin
            w_q       <= cfg_w;
            g_q       <= cfg_g;
            r_q       <= cfg_r;
            p_q       <= cfg_p;
            rows_done <= '0;
            rows_wr   <= '0;
            full      <= '0;
            issued    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            iss_bank  <= 1'b0;
            if (cfg_p > DEPTH16) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err <= 1'b0;
              if (cfg_w != '0 && cfg_g != '0 && cfg_r != '0) begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (wr_hs && wr_row_end) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
            rows_wr       <= rows_wr + 12'd1;
          end
          if (iss_go && iss_end) begin
            issued[iss_bank] <= 1'b1;
            iss_bank         <= ~iss_bank;
          end
          if (rd_row_end) begin
            full[rd_bank]   <= 1'b0;
            issued[rd_bank] <= 1'b0;
            rd_bank         <= ~rd_bank;
            rows_done       <= rows_done + 12'd1;
            if (rows_done == r_q - 12'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // write pointer: addr = x*G + g built by stepping G per beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_x    <= '0;
      wr_g    <= '0;
      wr_addr <= '0;
    end else if (cfg_hs) begin
      wr_x    <= '0;
      wr_g    <= '0;
      wr_addr <= '0;
    end else if (wr_hs) begin
      if (wr_row_end) begin
        wr_x    <= '0;
        wr_g    <= '0;
        wr_addr <= '0;
      end else if (wr_col_end) begin
        wr_x    <= '0;
        wr_g    <= wr_g + 4'd1;
        wr_addr <= AW'(wr_g) + AW'(1);
      end else begin
        wr_x    <= wr_x + 12'd1;
        wr_addr <= wr_addr + AW'(g_q);
      end
    end
  end

  // sequential read address and read-valid pipeline tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_addr  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= iss_go;
      rd_last_q <= iss_go & iss_end;
      if (cfg_hs) begin
        iss_addr <= '0;
      end else if (iss_go) begin
        iss_addr <= iss_end ? '0 : iss_addr + AW'(1);
      end
    end
  end

  // bank storage with registered read
  always_ff @(posedge clk) begin
    if (wr_hs && !wr_bank) mem0[wr_addr] <= s_axis_rr.tdata;
    if (wr_hs &&  wr_bank) mem1[wr_addr] <= s_axis_rr.tdata;
    if (iss_go) rd_data_q <= iss_bank ? mem1[iss_addr] : mem0[iss_addr];
  end

  // output prefetch: pop shifts entry 1 forward, push fills first free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_data[0] <= '0;
      f_data[1] <= '0;
      f_last    <= '0;
      f_cnt     <= '0;
    end else begin
      if (out_hs) begin
        f_data[0] <= f_data[1];
        f_last[0] <= f_last[1];
      end
      if (rd_vld_q) begin
        if (cnt_after_pop == 2'd0) begin
          f_data[0] <= rd_data_q;
          f_last[0] <= rd_last_q;
        end else begin
          f_data[1] <= rd_data_q;
          f_last[1] <= rd_last_q;
        end
      end
      f_cnt <= cnt_after_pop + {1'b0, rd_vld_q};
    end
  end

endmodule

// File: tb/tb_dmw_row_reorder.sv
// Self-checking bench for dmw_row_reorder. Input beats carry a unique tag
// {run id, row, group, pixel}; the expected pixel-major order of each row
// is queued when the row starts being driven and popped on every output
// handshake.
module tb_dmw_row_reorder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [11:0] rows_done;
  logic        cfg_err;

  int total_chk = 0;
  int bad_chk   = 0;
  logic [127:0] exp_q[$];

  dmw_row_reorder_if #(.DW(32))  cfg_if ();
  dmw_row_reorder_if #(.DW(128)) in_if  ();
  dmw_row_reorder_if #(.DW(128)) out_if ();

  dmw_row_reorder #(.DEPTH(2048), .AW(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_rrcfg (cfg_if),
    .s_axis_rr    (in_if),
    .m_axis_rr    (out_if),
    .busy         (busy),
    .rows_done    (rows_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] tag(input int id, input int row, input int gi, input int xi);
    return {32'(id), 32'(row), 32'(gi), 32'(xi)};
  endfunction

  // present one config word until it is accepted (bounded)
  task automatic send_cfg(input int w, input int g, input int r);
    int n;
    n = 0;
    cfg_if.tdata  = {4'hA, 12'(r), 4'(g), 12'(w)};
    cfg_if.tvalid = 1'b1;
    @(negedge clk);
    while (!cfg_if.tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_chk++;
    if (cfg_if.tready !== 1'b1) begin
      bad_chk++;
      $display("FAIL cfg_accept tready=%0b required=1", cfg_if.tready);
    end
    @(posedge clk); #1;
    cfg_if.tvalid = 1'b0;
  endtask

  // Stream r rows of W*G beats in group-major order and check the output.
  // lat = edge of first output valid minus edge of the last input handshake.
  task automatic run_rows(input int id, input int w, input int g, input int r, input bit stall,
                          input int abort_at, input int budget, output int lat);
    int p, total, in_cnt, out_cnt, cyc, rows_pushed, last_in, first_v;
    bit in_hs, out_hs, prev_hold, exp_rdy;
    logic [127:0] prev_data, exp_d;
    p = w * g; total = p * r;
    in_cnt = 0; out_cnt = 0; cyc = 0; rows_pushed = 0;
    last_in = -1; first_v = -1; prev_hold = 0; prev_data = '0;
    exp_q.delete();
    while (out_cnt < total && cyc < budget) begin
      if (in_cnt < total) begin
        if (in_cnt / p >= rows_pushed) begin
          for (int x = 0; x < w; x++)
            for (int gi = 0; gi < g; gi++)
              exp_q.push_back(tag(id, rows_pushed, gi, x));
          rows_pushed++;
        end
        in_if.tvalid = 1'b1;
        in_if.tdata  = tag(id, in_cnt / p, (in_cnt % p) / w, (in_cnt % p) % w);
      end else begin
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
      end
      out_if.tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      in_hs  = in_if.tvalid && in_if.tready;
      out_hs = out_if.tvalid && out_if.tready;
      if (first_v < 0 && out_if.tvalid) first_v = cyc - 1;
      if (in_hs && in_cnt == total - 1) last_in = cyc;
      if (prev_hold) begin
        total_chk++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== prev_data) begin
          bad_chk++;
          $display("FAIL hold_stable valid=%0b data=%h required valid=1 data=%h",
                   out_if.tvalid, out_if.tdata, prev_data);
        end
      end
      prev_hold = out_if.tvalid && !out_if.tready;
      prev_data = out_if.tdata;
      if (out_hs) begin
        total_chk++;
        if (exp_q.size() == 0) begin
          bad_chk++;
          $display("FAIL extra_out data=%h required=none", out_if.tdata);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_if.tdata !== exp_d) begin
            bad_chk++;
            $display("FAIL out_data beat=%0d got=%h required=%h", out_cnt, out_if.tdata, exp_d);
          end
        end
      end
      if (in_cnt < total) begin
        // banks holding unread rows = rows fully written - rows fully emitted
        exp_rdy = ((in_cnt / p) - (out_cnt / p)) < 2;
        total_chk++;
        if (in_if.tready !== exp_rdy) begin
          bad_chk++;
          $display("FAIL in_ready in=%0d out=%0d got=%0b required=%0b",
                   in_cnt, out_cnt, in_if.tready, exp_rdy);
        end
      end
      if (!stall && (out_cnt % p) != 0) begin
        total_chk++;
        if (out_if.tvalid !== 1'b1) begin
          bad_chk++;
          $display("FAIL out_gap beat=%0d valid=%0b required=1", out_cnt, out_if.tvalid);
        end
      end
      @(posedge clk); #1;
      if (in_hs)  in_cnt++;
      if (out_hs) out_cnt++;
      cyc++;
      if (abort_at >= 0 && in_cnt >= abort_at) break;
    end
    in_if.tvalid = 1'b0;
    lat = (last_in >= 0 && first_v >= 0) ? first_v - last_in : -1;
    if (abort_at < 0) begin
      total_chk++;
      if (out_cnt != total) begin
        bad_chk++;
        $display("FAIL out_count got=%0d required=%0d (cycle budget)", out_cnt, total);
      end
    end
  endtask

  task automatic test_reset();
    cfg_if.tvalid = 1'b0; cfg_if.tdata = '0;
    in_if.tvalid  = 1'b0; in_if.tdata  = '0;
    out_if.tready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_chk++;
    if (out_if.tvalid !== 1'b0 || out_if.tdata !== 128'd0 || in_if.tready !== 1'b0 ||
        cfg_if.tready !== 1'b1 || busy !== 1'b0 || rows_done !== 12'd0 || cfg_err !== 1'b0) begin
      bad_chk++;
      $display("FAIL reset_values ov=%0b od=%h ir=%0b cr=%0b busy=%0b rd=%0d err=%0b required 0,0,0,1,0,0,0",
               out_if.tvalid, out_if.tdata, in_if.tready, cfg_if.tready, busy, rows_done, cfg_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_small();
    int lat;
    send_cfg(4, 2, 1);
    run_rows(1, 4, 2, 1, 1'b0, -1, 200, lat);
    total_chk++;
    if (lat !== 2) begin
      bad_chk++;
      $display("FAIL small_latency got=%0d required=2", lat);
    end
    @(negedge clk);
    total_chk++;
    if (rows_done !== 12'd1 || busy !== 1'b0 || cfg_if.tready !== 1'b1) begin
      bad_chk++;
      $display("FAIL small_done rows_done=%0d busy=%0b cfg_rdy=%0b required 1,0,1",
               rows_done, busy, cfg_if.tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream(input bit stall, input int id);
    int lat;
    send_cfg(100, 4, 6);
    run_rows(id, 100, 4, 6, stall, -1, 30000, lat);
    @(negedge clk);
    total_chk++;
    if (rows_done !== 12'd6 || busy !== 1'b0 || exp_q.size() != 0) begin
      bad_chk++;
      $display("FAIL stream_done stall=%0b rows_done=%0d busy=%0b left=%0d required 6,0,0",
               stall, rows_done, busy, exp_q.size());
    end
    @(posedge clk); #1;
    out_if.tready = 1'b1;
  endtask

  task automatic test_cfg_err();
    int lat;
    send_cfg(1024, 4, 1);
    @(negedge clk);
    total_chk++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg_if.tready !== 1'b1) begin
      bad_chk++;
      $display("FAIL cfg_err_set err=%0b busy=%0b cfg_rdy=%0b required 1,0,1",
               cfg_err, busy, cfg_if.tready);
    end
    @(posedge clk); #1;
    send_cfg(8, 2, 1);
    @(negedge clk);
    total_chk++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      bad_chk++;
      $display("FAIL cfg_err_clear err=%0b busy=%0b required 0,1", cfg_err, busy);
    end
    @(posedge clk); #1;
    run_rows(3, 8, 2, 1, 1'b0, -1, 200, lat);
    @(negedge clk);
    total_chk++;
    if (rows_done !== 12'd1 || busy !== 1'b0) begin
      bad_chk++;
      $display("FAIL cfg_err_run rows_done=%0d busy=%0b required 1,0", rows_done, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r0();
    send_cfg(4095, 1, 3);
    send_cfg(4, 2, 0);
    @(negedge clk);
    total_chk++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || cfg_if.tready !== 1'b1) begin
      bad_chk++;
      $display("FAIL r0_cfg err=%0b busy=%0b cfg_rdy=%0b required 0,0,1",
               cfg_err, busy, cfg_if.tready);
    end
    @(posedge clk); #1;
    in_if.tvalid = 1'b1;
    in_if.tdata  = tag(4, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_chk++;
      if (in_if.tready !== 1'b0 || busy !== 1'b0) begin
        bad_chk++;
        $display("FAIL r0_idle cyc=%0d in_rdy=%0b busy=%0b required 0,0", i, in_if.tready, busy);
      end
      @(posedge clk); #1;
    end
    in_if.tvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    send_cfg(16, 8, 4);
    run_rows(5, 16, 8, 4, 1'b0, 2 * 128 + 40, 5000, lat);
    rst = 1'b1;
    @(negedge clk);
    total_chk++;
    if (out_if.tvalid !== 1'b0 || out_if.tdata !== 128'd0 || in_if.tready !== 1'b0 ||
        cfg_if.tready !== 1'b1 || busy !== 1'b0 || rows_done !== 12'd0 || cfg_err !== 1'b0) begin
      bad_chk++;
      $display("FAIL midreset_values ov=%0b od=%h ir=%0b cr=%0b busy=%0b rd=%0d err=%0b required 0,0,0,1,0,0,0",
               out_if.tvalid, out_if.tdata, in_if.tready, cfg_if.tready, busy, rows_done, cfg_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_if.tready = 1'b1;
    send_cfg(16, 8, 1);
    run_rows(6, 16, 8, 1, 1'b0, -1, 2000, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total_chk++;
      if (out_if.tvalid !== 1'b0) begin
        bad_chk++;
        $display("FAIL midreset_extra cyc=%0d valid=%0b required=0", i, out_if.tvalid);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total_chk++;
    if (rows_done !== 12'd1 || busy !== 1'b0) begin
      bad_chk++;
      $display("FAIL midreset_done rows_done=%0d busy=%0b required 1,0", rows_done, busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_small();
    test_stream(1'b0, 10);
    test_stream(1'b1, 11);
    test_cfg_err();
    test_r0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end
endmodule
